// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the M-extension divide unit.
package div_ctrl_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned WLEN        = 32;
    localparam int unsigned DIV_LATENCY = 65;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp,
        StDrain
    } div_state_t;

    typedef enum logic [1:0] {
        DvIdle,
        DvBusy,
        DvDone
    } diviter_state_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN - WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/diviter.sv
// Unsigned 64/64 restoring divider, one quotient bit per cycle; c = {remainder, quotient}.
module diviter
    import div_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                done_o,
    output logic [2*XLEN-1:0]   c_o
);

    diviter_state_t  state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [6:0]      cnt_q, cnt_d;

    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                   input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = {r, q[XLEN-1]};
        diff = sh - {1'b0, d};
        // Top bit of the 65-bit difference is the borrow: set means sh < d.
        if (!diff[XLEN]) begin
            return {diff[XLEN-1:0], q[XLEN-2:0], 1'b1};
        end
        return {sh[XLEN-1:0], q[XLEN-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DvIdle: begin
                if (valid_i) begin
                    // The load cycle already resolves the first quotient bit.
                    {rem_d, quo_d} = div_step('0, a_i, b_i);
                    dvs_d          = b_i;
                    cnt_d          = 7'(DIV_LATENCY - 2);
                    state_d        = DvBusy;
                end
            end
            DvBusy: begin
                {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
                cnt_d          = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = DvDone;
                end
            end
            DvDone: begin
                if (!valid_i) begin
                    state_d = DvIdle;
                end
            end
            default: state_d = DvIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= DvIdle;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

    // Idle reports done unless a new operation is being offered.
    assign done_o = (state_q == DvDone) || ((state_q == DvIdle) && !valid_i);
    assign c_o    = {rem_q, quo_q};

endmodule

// File: rtl/div_ctrl.sv
// RISC-V M-extension divide sequencer around diviter: sign handling, special cases, flush.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic             req_word_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    input  logic             flush_i
);

    div_state_t       state_q, state_d;
    div_op_t          op_q, op_d;
    logic             word_q, word_d;
    logic             a_neg_q, a_neg_d;
    logic             q_neg_q, q_neg_d;
    logic [XLEN-1:0]  mag_a_q, mag_a_d;
    logic [XLEN-1:0]  mag_b_q, mag_b_d;
    logic             div_valid_q, div_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic              div_done;
    logic [2*XLEN-1:0] div_c;

    div_op_t         req_op;
    logic            req_signed;
    logic [XLEN-1:0] a_ext, b_ext, int_min;
    logic            a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0] quo_fix, rem_fix;

    function automatic logic [XLEN-1:0] prep_operand(input logic [XLEN-1:0] v,
                                                     input logic            word,
                                                     input logic            sgn);
        if (!word) begin
            return v;
        end
        return sgn ? sext_word(v[WLEN-1:0]) : {{(XLEN - WLEN){1'b0}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [XLEN-1:0] select_result(input div_op_t         op,
                                                      input logic            word,
                                                      input logic [XLEN-1:0] quo,
                                                      input logic [XLEN-1:0] rem);
        logic [XLEN-1:0] v;
        v = (op == OpRem || op == OpRemu) ? rem : quo;
        return word ? sext_word(v[WLEN-1:0]) : v;
    endfunction

    always_comb begin
        req_op     = div_op_t'(req_op_i);
        req_signed = (req_op == OpDiv) || (req_op == OpRem);
        a_ext      = prep_operand(req_a_i, req_word_i, req_signed);
        b_ext      = prep_operand(req_b_i, req_word_i, req_signed);
        a_neg      = req_signed && a_ext[XLEN-1];
        b_neg      = req_signed && b_ext[XLEN-1];
        // Most-negative value for the operating width, as seen after extension.
        int_min    = req_word_i ? {{(XLEN - WLEN){1'b1}}, 1'b1, {(WLEN - 1){1'b0}}}
                                : {1'b1, {(XLEN - 1){1'b0}}};
        b_zero     = (b_ext == '0);
        ovf        = req_signed && (a_ext == int_min) && (b_ext == '1);
        quo_fix    = cond_neg(div_c[XLEN-1:0], q_neg_q);
        rem_fix    = cond_neg(div_c[2*XLEN-1:XLEN], a_neg_q);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        a_neg_d     = a_neg_q;
        q_neg_d     = q_neg_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        div_valid_d = div_valid_q;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;
        unique case (state_q)
            StIdle: begin
                if (!flush_i && req_valid_i) begin
                    op_d       = req_op;
                    word_d     = req_word_i;
                    a_neg_d    = a_neg;
                    q_neg_d    = a_neg ^ b_neg;
                    mag_a_d    = cond_neg(a_ext, a_neg);
                    mag_b_d    = cond_neg(b_ext, b_neg);
                    resp_tag_d = req_tag_i;
                    if (b_zero || ovf) begin
                        resp_data_d = select_result(req_op, req_word_i,
                                                    b_zero ? '1 : a_ext,
                                                    b_zero ? a_ext : '0);
                        state_d     = StResp;
                    end else begin
                        div_valid_d = 1'b1;
                        state_d     = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush_i) begin
                    state_d = StDrain;
                end else if (div_done) begin
                    div_valid_d = 1'b0;
                    resp_data_d = select_result(op_q, word_q, quo_fix, rem_fix);
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (flush_i || resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // diviter cannot be aborted; let it finish and drop the result.
                if (div_done) begin
                    div_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            op_q        <= OpDiv;
            word_q      <= 1'b0;
            a_neg_q     <= 1'b0;
            q_neg_q     <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            div_valid_q <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_q      <= word_d;
            a_neg_q     <= a_neg_d;
            q_neg_q     <= q_neg_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            div_valid_q <= div_valid_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
        end
    end

    diviter u_diviter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (div_valid_q),
        .a_i     (mag_a_q),
        .b_i     (mag_b_q),
        .done_o  (div_done),
        .c_o     (div_c)
    );

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_data_o  = resp_data_q;
    assign resp_tag_o   = resp_tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: reference arithmetic model, latency, backpressure, flush, reset.
module tb_div_ctrl;

    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        flush;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     n_pass  = 0;
    int     n_total = 0;
    longint last_acc;

    always #(PERIOD / 2) clk = ~clk;

    div_ctrl #(.TAG_W(5)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_word_i   (req_word),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_tag_i    (req_tag),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_tag_o   (resp_tag),
        .flush_i      (flush)
    );

    function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q64, r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32;
            end else if (op[0]) begin
                q32 = a32 / b32; r32 = a32 % b32;
            end else if (a32 == 32'h8000_0000 && b32 == '1) begin
                q32 = a32; r32 = '0;
            end else begin
                q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
            end
            q64 = {{32{q32[31]}}, q32};
            r64 = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q64 = '1; r64 = a;
            end else if (op[0]) begin
                q64 = a / b; r64 = a % b;
            end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = '0;
            end else begin
                q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
            end
        end
        return op[1] ? r64 : q64;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        end
        return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input bit push);
        exp_t e;
        int   n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        else n_pass++;
        req_op = op; req_word = w; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        @(posedge clk);
        last_acc = longint'($time);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e.data = model(op, w, a, b);
            e.tag  = tag;
            e.lat  = is_special(op, w, a, b) ? 1 : 66;
            e.acc  = last_acc;
            sb.push_back(e);
        end
    endtask

    task automatic check_resp(input int hold);
        exp_t e;
        int   n = 0;
        int   lat;
        while (resp_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        n_total++;
        if (resp_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL resp_wait: resp_valid=%b sb_size=%0d required valid with entry",
                     resp_valid, sb.size());
            resp_ready = 1'b1;
            return;
        end
        n_pass++;
        e   = sb.pop_front();
        lat = int'((longint'($time) - 1 - e.acc) / PERIOD) + 1;
        n_total++;
        if (resp_data !== e.data) $display("FAIL resp_data: got %h required %h", resp_data, e.data);
        else n_pass++;
        n_total++;
        if (resp_tag !== e.tag) $display("FAIL resp_tag: got %0d required %0d", resp_tag, e.tag);
        else n_pass++;
        n_total++;
        if (lat !== e.lat) $display("FAIL latency: got %0d required %0d", lat, e.lat);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== e.data ||
                resp_tag !== e.tag)
                $display("FAIL hold_stable: cyc %0d valid=%b ready=%b data=%h tag=%0d required 1 0 %h %0d",
                         i, resp_valid, req_ready, resp_data, resp_tag, e.data, e.tag);
            else n_pass++;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL post_handshake: valid=%b ready=%b required 0 1", resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_tag !== 5'd0)
            $display("FAIL reset_state: ready=%b valid=%b data=%h tag=%0d required 1 0 0 0",
                     req_ready, resp_valid, resp_data, resp_tag);
        else n_pass++;
    endtask

    task automatic test_divu_basic;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd1, 1'b1); check_resp(0);
        issue(2'b11, 1'b0, 64'd100, 64'd7, 5'd2, 1'b1); check_resp(0);
    endtask

    task automatic test_signs;
        issue(2'b00, 1'b0, -64'sd7, 64'd2, 5'd3, 1'b1);  check_resp(0);
        issue(2'b10, 1'b0, -64'sd7, 64'd2, 5'd4, 1'b1);  check_resp(0);
        issue(2'b00, 1'b0, 64'd7, -64'sd2, 5'd5, 1'b1);  check_resp(0);
        issue(2'b10, 1'b0, 64'd7, -64'sd2, 5'd6, 1'b1);  check_resp(0);
    endtask

    task automatic test_special;
        issue(2'b01, 1'b0, 64'h1234, 64'd0, 5'd7, 1'b1);                  check_resp(0);
        issue(2'b10, 1'b0, 64'd5, 64'd0, 5'd8, 1'b1);                     check_resp(0);
        issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd9, 1'b1);      check_resp(0);
        issue(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd10, 1'b1);     check_resp(0);
    endtask

    task automatic test_word;
        issue(2'b00, 1'b1, 64'h0000_0001_8000_0000, '1, 5'd11, 1'b1);     check_resp(0);
        issue(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12, 1'b1);  check_resp(0);
        issue(2'b10, 1'b1, 64'hABCD_0000_FFFF_FFF3, 64'h5_0000_0004, 5'd13, 1'b1); check_resp(0);
        issue(2'b11, 1'b1, 64'h7, 64'hFFFF_FFFF_0000_0000, 5'd14, 1'b1);  check_resp(0);
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        issue(2'b01, 1'b0, 64'd9, 64'd0, 5'd15, 1'b1);
        check_resp(10);
        resp_ready = 1'b0;
        issue(2'b00, 1'b0, -64'sd1000, 64'd33, 5'd16, 1'b1);
        check_resp(10);
    endtask

    task automatic test_flush_busy;
        int n = 0;
        int lat;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd17, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_total++;
        while (req_ready !== 1'b1 && n < 200) begin
            if (resp_valid !== 1'b0) break;
            if (n == 5) flush = 1'b1;
            @(posedge clk); #1; n++;
            flush = 1'b0;
        end
        lat = int'((longint'($time) - 1 - last_acc) / PERIOD) + 1;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || lat != 66)
            $display("FAIL drain: valid=%b ready=%b ready_at=%0d required 0 1 66",
                     resp_valid, req_ready, lat);
        else n_pass++;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd18, 1'b1);
        check_resp(0);
    endtask

    task automatic test_flush_done;
        int n = 0;
        issue(2'b00, 1'b0, -64'sd500, 64'd3, 5'd19, 1'b0);
        repeat (64) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL flush_on_done: valid=%b ready=%b required 0 0", resp_valid, req_ready);
        else n_pass++;
        n_total++;
        while (req_ready !== 1'b1 && n < 20 && resp_valid === 1'b0) begin
            @(posedge clk); #1; n++;
        end
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL drain_exit: valid=%b ready=%b required 0 1", resp_valid, req_ready);
        else n_pass++;
        issue(2'b10, 1'b0, -64'sd500, 64'd3, 5'd20, 1'b1);
        check_resp(0);
    endtask

    task automatic test_flush_idle_resp;
        req_op = 2'b01; req_word = 1'b0; req_a = 64'd4; req_b = 64'd0; req_tag = 5'd21;
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b0;
        n_total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL flush_idle: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        else n_pass++;
        resp_ready = 1'b0;
        issue(2'b01, 1'b0, 64'd4, 64'd0, 5'd22, 1'b0);
        n_total++;
        if (resp_valid !== 1'b1) $display("FAIL resp_before_flush: valid=%b required 1", resp_valid);
        else n_pass++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        resp_ready = 1'b1;
        n_total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL flush_resp: valid=%b ready=%b required 0 1", resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        issue(2'b01, 1'b0, 64'd999, 64'd10, 5'd23, 1'b0);
        repeat (30) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_tag !== 5'd0)
            $display("FAIL reset_mid: ready=%b valid=%b data=%h tag=%0d required 1 0 0 0",
                     req_ready, resp_valid, resp_data, resp_tag);
        else n_pass++;
        repeat (80) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL reset_no_result: resp_valid seen=1 required 0");
        else n_pass++;
        issue(2'b11, 1'b0, 64'd999, 64'd10, 5'd24, 1'b1);
        check_resp(0);
    endtask

    task automatic test_back_to_back;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = (i == 3) ? 64'd0 : {$urandom_range(0, 1) == 0 ? 32'd0 : $urandom, $urandom};
            issue(op, w, a, b, 5'(25 + i), 1'b1);
            check_resp(0);
        end
    endtask

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_word = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0; resp_ready = 1'b1; flush = 1'b0;
        test_reset();
        test_divu_basic();
        test_signs();
        test_special();
        test_word();
        test_backpressure();
        test_flush_busy();
        test_flush_done();
        test_flush_idle_resp();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer that wraps the unsigned iterative divider `diviter` and turns it into the RISC-V M-extension divide unit. It sits in the execute stage and accepts DIV/DIVU/REM/REMU and their 32-bit W forms over a valid/ready handshake. It resolves signs, divide-by-zero and signed overflow, and returns a tagged 64-bit result. It also absorbs pipeline flushes even though `diviter` itself cannot be aborted.

## Interface
- `TAG_W`, default 5, width of the pass-through request tag (ROB index).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_word`  in  1  W form: 32-bit operands, sign-extended 32-bit result.
- `req_a`, `req_b`  in  64  dividend and divisor.
- `req_tag`  in  TAG_W  returned unchanged with the result.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result when `resp_valid && resp_ready`.
- `resp_data`  out  64  result.
- `resp_tag`  out  TAG_W  tag of that result.
- `flush`  in  1  kills the in-flight and held operation.

## Operation
- **States.** IDLE, BUSY, RESP, DRAIN. Reset puts the block in IDLE with `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_tag`=0 and `diviter` valid=0.
- **IDLE.**
  - `req_ready`=1.
  - On accept, latch op, word, tag, the sign flags and the operand magnitudes.
  - Special case: go straight to RESP with the precomputed result.
  - Otherwise go to BUSY with `diviter` valid=1 and a=|A|, b=|B|.
- **Operand prep.**
  - W form: A and B are the low 32 bits of `req_a` and `req_b`, sign-extended (signed ops) or zero-extended (unsigned ops) to 64 bits.
  - Signed ops: magnitude = two's-complement absolute value. The 64-bit most-negative value maps to itself, which is correct as unsigned.
- **Special cases.** Neither case starts `diviter`.
  - B==0: quotient = all ones, remainder = A.
  - Signed overflow, i.e. A = most negative for the width and B = -1: quotient = A, remainder = 0.
- **BUSY.**
  - `diviter` valid is held at 1 until its `done` is seen. `done` is qualified by the BUSY state only, because `diviter` drives `done` high while idle.
  - On `done`, capture `c`: quotient = c[63:0], remainder = c[127:64].
  - Fix up the sign: the quotient is negated if sign(A) != sign(B) on signed ops; the remainder takes sign(A).
  - Select per op. For W forms, sign-extend bit 31 of the selected value.
  - Then go to RESP.
- **RESP.**
  - `resp_valid`=1, with `resp_data` and `resp_tag` held stable until the handshake.
  - `req_ready`=0.
  - On `resp_ready`, go to IDLE. No back-to-back accept happens in the same cycle.
- **flush** has priority over every other event in the same cycle:
  - IDLE: a simultaneous request is not accepted.
  - BUSY: go to DRAIN.
  - RESP: drop `resp_valid` next cycle and go to IDLE.
- **DRAIN.**
  - `req_ready`=0 and `resp_valid`=0.
  - Wait for `diviter` `done`, discard the result, then go to IDLE.
  - A further `flush` in DRAIN is ignored.
- **Reset mid-operation.** Reset returns both `div_ctrl` and `diviter` to their reset state in the same cycle; no result is produced.

## Timing
- The accept edge is T0.
- Special case: `resp_valid` is high in the cycle after T0, so latency is 1.
- Divider path: latency = `DIV_LATENCY` + 1. `DIV_LATENCY` is the number of cycles from `diviter` valid rising to `done` in BUSY, fixed at 65. The result is registered on the `done` edge and `resp_valid` rises the cycle after.
- Throughput: one operation in flight. After a RESP handshake at edge Tn, `req_ready` is high again in cycle Tn+1.
- Every output is registered. `req_ready` is a pure function of state.

## Structure
- Shared package (alongside `common`):
  - enum `div_op_t` for the op codes;
  - state enum `div_state_t`;
  - constant `DIV_LATENCY` = 65;
  - constants `XLEN` = 64 and `WLEN` = 32.
- One sub-module instance: `diviter` (unsigned 64/64, c = {remainder, quotient}).
- Sign prep and fix-up are combinational functions inside `div_ctrl`; no further sub-modules.

## Test plan
- **DIVU, basic:** A=100, B=7, `resp_ready`=1 → `resp_data`=14 after 66 cycles. REMU with the same operands → 2. Tags are echoed.
- **DIV/REM signs:** A=-7, B=2 → DIV -3, REM -1. A=7, B=-2 → DIV -3, REM 1.
- **Special cases, 1-cycle latency:**
  - DIVU by 0 → 0xFFFF_FFFF_FFFF_FFFF.
  - REM of 5 by 0 → 5.
  - DIV of 0x8000_0000_0000_0000 by -1 → 0x8000_0000_0000_0000.
  - REM with the same operands → 0.
- **W forms:**
  - DIVW with A=0x0000_0001_8000_0000, B=-1 → 0xFFFF_FFFF_8000_0000.
  - DIVUW with A=0xFFFF_FFFF, B=1 → 0xFFFF_FFFF_FFFF_FFFF (sign-extended bit 31).
- **Backpressure:** hold `resp_ready`=0 for 10 cycles in RESP → `resp_data` and `resp_tag` are stable and `req_ready`=0. Release → IDLE next cycle.
- **Flush in BUSY at cycle 20:**
  - DRAIN holds `req_ready`=0 until `diviter` finishes, and no `resp_valid` is produced.
  - A following request (100/7) returns the correct 14.
  - Also cover flush coinciding with `done`, and reset asserted mid-BUSY.
